// File: rtl/sram_req_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : sram_req_tracker
//  Purpose  : Tracks address-accepted / data-pending requests between a
//             pipeline stage and an in-order SRAM-like bus. Caps the number
//             of outstanding requests at MAX_OUT and, after a pipeline
//             flush, silently discards the responses of every request that
//             was still pending so the stage never sees stale data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_OUT  (1..15) maximum outstanding requests
//    CNT_W    counter width, 2**CNT_W must exceed MAX_OUT
//  Build option
//    TRACKER_FLUSH_HOLD_EN  when defined, no new request issues while
//                           discards are still pending (DRAIN)
//  Ports
//    clk, reset                      clock, async active-high reset
//    up_req/wr/size/wstrb/addr/wdata request from the pipeline stage
//    up_addr_ok                      request accepted this cycle
//    up_data_ok, up_rdata            response forwarded to the stage
//    dn_req/wr/size/wstrb/addr/wdata request to the bus
//    dn_addr_ok, dn_data_ok, dn_rdata bus handshake and response
//    flush                           one-cycle pipeline cancel pulse
//    out_cnt, disc_cnt               outstanding / still-to-discard counts
//    state                           00 IDLE, 01 BUSY, 10 DRAIN
//    err                             sticky: response seen with nothing pending
// ============================================================================
module sram_req_tracker #(
   parameter int MAX_OUT = 2,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   // pipeline side
   input  logic             up_req,
   input  logic             up_wr,
   input  logic [1:0]       up_size,
   input  logic [3:0]       up_wstrb,
   input  logic [31:0]      up_addr,
   input  logic [31:0]      up_wdata,
   output logic             up_addr_ok,
   output logic             up_data_ok,
   output logic [31:0]      up_rdata,
   // bus side
   output logic             dn_req,
   output logic             dn_wr,
   output logic [1:0]       dn_size,
   output logic [3:0]       dn_wstrb,
   output logic [31:0]      dn_addr,
   output logic [31:0]      dn_wdata,
   input  logic             dn_addr_ok,
   input  logic             dn_data_ok,
   input  logic [31:0]      dn_rdata,
   // control / status
   input  logic             flush,
   output logic [CNT_W-1:0] out_cnt,
   output logic [CNT_W-1:0] disc_cnt,
   output logic [1:0]       state,
   output logic             err
);

   localparam logic [CNT_W-1:0] c_MAX_OUT = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_out_cnt;
   logic [CNT_W-1:0] r_disc_cnt;
   logic             r_err;

   logic             w_slot_free;
   logic             w_issue_ok;
   logic             w_acc;
   logic             w_rsp;
   logic             w_drop;
   logic             w_stray;
   logic [CNT_W-1:0] w_out_cnt_nxt;
   logic [CNT_W-1:0] w_disc_cnt_nxt;

   // Request fields pass straight through; only the handshake is tracked.
   assign dn_wr    = up_wr;
   assign dn_size  = up_size;
   assign dn_wstrb = up_wstrb;
   assign dn_addr  = up_addr;
   assign dn_wdata = up_wdata;
   assign up_rdata = dn_rdata;

   // Slot availability looks at the registered count only, so a response
   // arriving this cycle cannot free a slot for a request in the same cycle.
   assign w_slot_free = (r_out_cnt < c_MAX_OUT);

`ifdef TRACKER_FLUSH_HOLD_EN
   assign w_issue_ok = w_slot_free & (r_disc_cnt == '0);
`else
   assign w_issue_ok = w_slot_free;
`endif

   assign dn_req = up_req & w_issue_ok;

   // An acceptance during reset would be lost by the held registers, so the
   // stage must not be told it was accepted.
   assign w_acc      = dn_req & dn_addr_ok & ~reset;
   assign up_addr_ok = w_acc;

   // Responses only count when something is outstanding; otherwise they are
   // stray, ignored and flagged. out_cnt is held at 0 during reset, which
   // keeps up_data_ok low there as well.
   assign w_rsp      = dn_data_ok & (r_out_cnt != '0);
   assign w_stray    = dn_data_ok & (r_out_cnt == '0);
   assign w_drop     = w_rsp & (r_disc_cnt != '0);
   assign up_data_ok = w_rsp & (r_disc_cnt == '0);

   always_comb begin
      w_out_cnt_nxt = r_out_cnt;
      if (w_acc && !w_rsp) begin
         w_out_cnt_nxt = r_out_cnt + c_ONE;
      end else if (!w_acc && w_rsp) begin
         w_out_cnt_nxt = r_out_cnt - c_ONE;
      end
   end

   // A flush marks everything still pending after this edge for discard,
   // including a request accepted in the flush cycle itself. Any response in
   // the flush cycle is already excluded from out_cnt_next, and it was either
   // forwarded (old disc_cnt 0) or counted as a drop against the old value.
   always_comb begin
      w_disc_cnt_nxt = r_disc_cnt;
      if (flush) begin
         w_disc_cnt_nxt = w_out_cnt_nxt;
      end else if (w_drop) begin
         w_disc_cnt_nxt = r_disc_cnt - c_ONE;
      end
   end

   // Counters, sticky error and the state register. The state is derived
   // from the next-cycle counter values so it always agrees with them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_cnt  <= '0;
         r_disc_cnt <= '0;
         r_err      <= 1'b0;
         r_state    <= ST_IDLE;
      end else begin
         r_out_cnt  <= w_out_cnt_nxt;
         r_disc_cnt <= w_disc_cnt_nxt;
         if (w_stray) begin
            r_err <= 1'b1;
         end
         if (w_disc_cnt_nxt != '0) begin
            r_state <= ST_DRAIN;
         end else if (w_out_cnt_nxt != '0) begin
            r_state <= ST_BUSY;
         end else begin
            r_state <= ST_IDLE;
         end
      end
   end

   assign out_cnt  = r_out_cnt;
   assign disc_cnt = r_disc_cnt;
   assign state    = r_state;
   assign err      = r_err;

endmodule
`default_nettype wire
